// File: rtl/sid_bus_writer.sv
// Buffered host-to-SID register writer.
// Requests queue in a FIFO and are replayed as phi2-aligned bus cycles.
module sid_bus_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sid_clk,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       sid_cs_n,
    output logic       sid_rw,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       sid_data_oe,
    output logic       busy,
    output logic [4:0] fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            sid_clk_d;
    logic            sid_rise;
    logic            sid_fall;
    logic [12:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [4:0]      level_nx;
    logic            push;
    logic            pop;
    logic [2:0]      cnt;
    logic [2:0]      cnt_nx;
    logic            cs_n_nx;
    logic            rw_nx;
    logic            oe_nx;

    assign sid_rise = sid_clk & ~sid_clk_d;
    assign sid_fall = ~sid_clk & sid_clk_d;
    assign push     = wr_valid & wr_ready;
    assign level_nx = fifo_level + {4'd0, push} - {4'd0, pop};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        cs_n_nx  = sid_cs_n;
        rw_nx    = sid_rw;
        oe_nx    = sid_data_oe;
        unique case (state)
            IDLE: begin
                if (sid_fall && fifo_level != 5'd0) begin
                    pop      = 1'b1;
                    cs_n_nx  = 1'b0;
                    rw_nx    = 1'b0;
                    oe_nx    = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (sid_rise)
                    state_nx = ACTIVE;
            end
            ACTIVE: begin
                // falling phi2 is where the SID latches the write
                if (sid_fall) begin
                    cnt_nx   = 3'(HOLD_CYCLES - 1);
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 3'd0) begin
                    cs_n_nx  = 1'b1;
                    rw_nx    = 1'b1;
                    oe_nx    = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {wr_addr, wr_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sid_clk_d   <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= 5'd0;
            wr_ready    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
            cnt         <= 3'd0;
            sid_cs_n    <= 1'b1;
            sid_rw      <= 1'b1;
            sid_data_oe <= 1'b0;
            sid_addr    <= 5'd0;
            sid_data    <= 8'd0;
        end else begin
            sid_clk_d   <= sid_clk;
            fifo_level  <= level_nx;
            wr_ready    <= (level_nx != 5'(FIFO_DEPTH));
            busy        <= (level_nx != 5'd0) || (state_nx != IDLE);
            state       <= state_nx;
            cnt         <= cnt_nx;
            sid_cs_n    <= cs_n_nx;
            sid_rw      <= rw_nx;
            sid_data_oe <= oe_nx;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr     <= rptr + 1'b1;
                sid_addr <= mem[rptr][12:8];
                sid_data <= mem[rptr][7:0];
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_writer.sv
// Bench for sid_bus_writer: directed and random writes checked
// cycle by cycle against a queue-and-window model of the bus.
module tb_sid_bus_writer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int HALF  = 10;
    localparam int INF   = 32'h7fffffff;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sid_clk = 1'b0;
    logic       wr_valid = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_ready;
    logic       sid_cs_n;
    logic       sid_rw;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_data_oe;
    logic       busy;
    logic [4:0] fifo_level;

    sid_bus_writer #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sid_clk    (sid_clk),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sid_cs_n   (sid_cs_n),
        .sid_rw     (sid_rw),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_data_oe(sid_data_oe),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    ent_t q[$];
    logic e_cs_n;
    logic [4:0] e_addr;
    logic [7:0] e_data;
    int   e_level;
    logic e_ready;
    logic e_busy;
    logic open;
    int   close_at;
    logic seen;
    int   now = 0;
    int   ph = 0;
    logic rst_req = 1'b0;
    logic acc = 1'b0;
    logic prev_cs = 1'b1;
    int   d_starts = 0;
    int   starts[$];
    logic track = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_cs_n   = 1'b1;
        e_addr   = 5'd0;
        e_data   = 8'd0;
        e_level  = 0;
        e_ready  = 1'b0;
        e_busy   = 1'b0;
        open     = 1'b0;
        close_at = INF;
        seen     = 1'b0;
    endtask

    task automatic check_outputs();
        chk("cs_n", sid_cs_n, e_cs_n);
        chk("rw", sid_rw, e_cs_n);
        chk("oe", sid_data_oe, !e_cs_n);
        chk("addr", sid_addr, e_addr);
        chk("data", sid_data, e_data);
        chk("level", fifo_level, e_level);
        chk("ready", wr_ready, e_ready);
        chk("busy", busy, e_busy);
        if (prev_cs === 1'b1 && sid_cs_n === 1'b0) begin
            d_starts++;
            if (track)
                starts.push_back(now);
        end
        prev_cs = sid_cs_n;
    endtask

    // One clk: check the current outputs, drive the next inputs,
    // then predict what the coming posedge produces.
    task automatic tick(input logic v, input logic [4:0] a,
                        input logic [7:0] d);
        logic fall;
        ent_t e;
        @(negedge clk);
        check_outputs();
        rst_n    = rst_req;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        ph       = (ph + 1) % (2 * HALF);
        sid_clk  = (ph >= HALF);
        acc      = 1'b0;
        now++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fall = seen && !sid_clk;
        seen = sid_clk;
        if (open && now == close_at) begin
            open   = 1'b0;
            e_cs_n = 1'b1;
        end else if (open && fall && close_at == INF) begin
            close_at = now + HOLD;
        end
        if (!open && fall && q.size() > 0) begin
            e        = q.pop_front();
            e_addr   = e.a;
            e_data   = e.d;
            e_cs_n   = 1'b0;
            open     = 1'b1;
            close_at = INF;
        end
        if (v && e_ready) begin
            q.push_back('{a, d});
            acc = 1'b1;
        end
        e_level = q.size();
        e_ready = (e_level != DEPTH);
        e_busy  = (q.size() != 0) || open;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 5'($urandom), 8'($urandom));
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d);
        int g = 0;
        do begin
            tick(1'b1, a, d);
            g++;
        end while (!acc && g < 200);
        chk("push_accept", acc, 1'b1);
    endtask

    task automatic to_fall_next();
        while (((ph + 1) % (2 * HALF)) != 0)
            idle(1);
    endtask

    task automatic drain();
        int g = 0;
        while ((e_busy || open) && g < 500) begin
            idle(1);
            g++;
        end
        idle(2);
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        model_reset();
        #1 rst_n = 1'b0;
        idle(4);
        chk("rst_ready", wr_ready, 1'b0);
        rst_req = 1'b1;
        idle(1);
        idle(1);
        chk("ready_after_rst", wr_ready, 1'b1);
        idle(25);

        // single write
        push(5'h18, 8'h0F);
        s = 0;
        while (!open && s < 100) begin
            idle(1);
            s++;
        end
        idle(1);
        chk("single_cs", sid_cs_n, 1'b0);
        chk("single_addr", sid_addr, 5'h18);
        chk("single_data", sid_data, 8'h0F);
        drain();

        // fill past depth
        s = d_starts;
        to_fall_next();
        idle(1);
        for (int i = 0; i < 4; i++)
            push(5'(i + 1), 8'(8'hA0 + i));
        tick(1'b1, 5'd5, 8'hA4);
        chk("fill_level", fifo_level, 5'd4);
        chk("fill_ready", wr_ready, 1'b0);
        chk("fill_5th_held", acc, 1'b0);
        push(5'd5, 8'hA4);
        drain();
        chk("fill_windows", d_starts - s, 5);

        // throughput: four queued writes
        to_fall_next();
        idle(1);
        s = d_starts;
        starts.delete();
        track = 1'b1;
        for (int i = 0; i < 4; i++)
            push(5'($urandom), 8'($urandom));
        drain();
        track = 1'b0;
        chk("thru_windows", d_starts - s, 4);
        for (int i = 1; i < starts.size(); i++)
            chk("thru_gap", starts[i] - starts[i-1], 4 * HALF);

        // push on the fall cycle with an empty FIFO
        to_fall_next();
        tick(1'b1, 5'h05, 8'h55);
        idle(2);
        chk("fall_push_no_start", sid_cs_n, 1'b1);
        to_fall_next();
        idle(2);
        chk("fall_push_next", sid_cs_n, 1'b0);
        chk("fall_push_addr", sid_addr, 5'h05);
        drain();

        // simultaneous push and pop at level 2, then random traffic
        s = d_starts;
        to_fall_next();
        idle(1);
        push(5'h11, 8'hC1);
        push(5'h12, 8'hC2);
        to_fall_next();
        chk("pp_pre_level", fifo_level, 5'd2);
        tick(1'b1, 5'h13, 8'hC3);
        idle(1);
        chk("pp_level", fifo_level, 5'd2);
        for (int i = 0; i < 17; i++) begin
            push(5'($urandom), 8'($urandom));
            idle($urandom_range(0, 3));
        end
        drain();
        chk("sb_count", d_starts - s, 20);

        // reset during the active phase with two entries queued
        to_fall_next();
        idle(1);
        for (int i = 0; i < 3; i++)
            push(5'(5'h1C + i), 8'(8'h70 + i));
        s = 0;
        while (!(open && sid_clk) && s < 100) begin
            idle(1);
            s++;
        end
        idle(3);
        chk("pre_rst_level", fifo_level, 5'd2);
        chk("pre_rst_cs", sid_cs_n, 1'b0);
        #2;
        rst_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_cs_async", sid_cs_n, 1'b1);
        chk("rst_oe_async", sid_data_oe, 1'b0);
        chk("rst_level_async", fifo_level, 5'd0);
        model_reset();
        idle(3);
        rst_req = 1'b1;
        idle(1);
        s = d_starts;
        idle(80);
        chk("post_rst_cycles", d_starts - s, 0);
        chk("post_rst_level", fifo_level, 5'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/sid_bus_writer.md
SID_BUS_WRITER -- requirements
Module: sid_bus_writer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered write requests (power of two, 2..16).
REQ-002 Parameter: HOLD_CYCLES, 2, clk cycles sid_cs_n stays low after the detected sid_clk falling edge (1..7).
REQ-003 Port: clk  input  1  system clock (20 MHz); sid_clk is generated in this clock domain.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: sid_clk  input  1  SID phi2 (1 MHz), synchronous to clk.
REQ-006 Port: wr_valid  input  1  host write request valid.
REQ-007 Port: wr_ready  output  1  block accepts request this cycle.
REQ-008 Port: wr_addr  input  5  SID register address.
REQ-009 Port: wr_data  input  8  SID register data.
REQ-010 Port: sid_cs_n  output  1  SID chip select, active low.
REQ-011 Port: sid_rw  output  1  SID R/W (1 = read, 0 = write).
REQ-012 Port: sid_addr  output  5  SID address bus.
REQ-013 Port: sid_data  output  8  SID data bus value.
REQ-014 Port: sid_data_oe  output  1  data bus output enable for the external tristate.
REQ-015 Port: busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-016 Port: fifo_level  output  5  number of occupied FIFO entries.

Function
REQ-017 Edge detect: sid_clk_d is sid_clk registered; sid_rise = sid_clk & ~sid_clk_d; sid_fall = ~sid_clk & sid_clk_d; each is one clk wide.
REQ-018 FIFO: {wr_addr, wr_data} is pushed when wr_valid & wr_ready; wr_ready = (fifo_level != FIFO_DEPTH), independent of a same-cycle pop.
REQ-019 The FIFO is first-in first-out; the read and write pointers wrap modulo FIFO_DEPTH; fifo_level updates by +1 on push, -1 on pop, and is unchanged on simultaneous push and pop.
REQ-020 A push in cycle N is not visible to the FSM until cycle N+1; an empty FIFO is never popped.
REQ-021 FSM states: IDLE, SETUP, ACTIVE, HOLD.
REQ-022 IDLE: on sid_fall with the FIFO non-empty, pop the FIFO, register the entry into sid_addr/sid_data, and set sid_cs_n=0, sid_rw=0, sid_data_oe=1 in the same registered update -> SETUP; otherwise remain in IDLE.
REQ-023 SETUP (phi2 low): hold the bus unchanged; on sid_rise -> ACTIVE.
REQ-024 ACTIVE (phi2 high): hold the bus unchanged; on sid_fall (the SID latch edge) load the hold counter with HOLD_CYCLES-1 -> HOLD.
REQ-025 HOLD: keep the bus; decrement the counter each clk; when the counter is 0, drive sid_cs_n=1, sid_rw=1, sid_data_oe=0 -> IDLE.
REQ-026 sid_addr and sid_data keep their last values after a write; only sid_cs_n, sid_rw and sid_data_oe return to idle levels.
REQ-027 The sid_fall that ends ACTIVE never starts a new write; back-to-back writes occur on alternate phi2 cycles (max rate 1 write per 2 sid_clk periods).
REQ-028 Every output is registered; no output depends combinationally on wr_valid, except wr_ready, which is registered state only.
REQ-029 sid_cs_n is low for exactly one full phi2-high phase per accepted request; no request is dropped or duplicated.

Reset
REQ-030 While rst_n=0, asynchronously force: sid_cs_n=1, sid_rw=1, sid_addr=0, sid_data=0, sid_data_oe=0, FSM=IDLE, FIFO empty (fifo_level=0), wr_ready=0, busy=0, sid_clk_d=0, hold counter=0.
REQ-031 wr_ready rises in the first clk after rst_n deasserts.
REQ-032 A reset asserted mid-write aborts the write immediately (sid_cs_n=1 without waiting for clk) and discards all queued entries.
REQ-033 Reset deassertion is synchronised to clk externally; the block samples no edges during the reset cycle.

Verification
REQ-034 Single write: push addr=0x18, data=0x0F while idle -> at the next sid_fall sid_cs_n=0, sid_addr=0x18, sid_data=0x0F, sid_rw=0; this holds through one phi2-high phase; sid_cs_n returns to 1 HOLD_CYCLES clk after the following sid_fall.
REQ-035 Fill: push 5 requests back-to-back with FIFO_DEPTH=4 -> wr_ready drops after the 4th push; fifo_level=4; the 5th request is accepted only after the first pop; output order matches input order.
REQ-036 Throughput: 4 queued writes -> sid_cs_n low windows start on every second sid_fall; exactly 4 windows occur; busy=0 after the last HOLD completes.
REQ-037 Push on sid_fall cycle with the FIFO empty -> no write starts that edge; the write starts on the next sid_fall.
REQ-038 Assert rst_n=0 during ACTIVE with 2 entries queued -> sid_cs_n=1 and sid_data_oe=0 asynchronously; after release fifo_level=0 and no further bus cycles occur.
REQ-039 Simultaneous push and pop at fifo_level=2 -> fifo_level stays 2 and no data corruption occurs across pointer wrap-around (20 writes in total checked against a scoreboard).
